// File: rtl/demux_seq_pkg.sv
// demux_seq_pkg -- shared constants and types for the demux bit sequencer.
//   SEL_W      : demux select width
//   NUM_CH     : channel count (2**SEL_W)
//   GAP_CNT_W  : width of the inter-word gap counter (GAP range 0..15)
//   seq_state_t: sequencer FSM states
package demux_seq_pkg;

  localparam int unsigned SEL_W     = 3;
  localparam int unsigned NUM_CH    = 2**SEL_W;
  localparam int unsigned GAP_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/demux_next_ch.sv
// demux_next_ch -- combinational search for the next enabled channel.
// Build option: SEQ_MSB_FIRST_EN selects a downward scan (next lower set
// mask bit); otherwise the scan goes upward (next higher set mask bit).
// Ports:
//   mask : channel enables of the word being shifted
//   idx  : channel currently on the demux
//   nxt  : next enabled channel in scan order (0 when none)
//   last : no enabled channel remains after idx
module demux_next_ch #(
  parameter  int unsigned SEL_W  = demux_seq_pkg::SEL_W,
  localparam int unsigned NUM_CH = 2**SEL_W
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  idx,
  output logic [SEL_W-1:0]  nxt,
  output logic              last
);

  // last doubles as the "nothing found yet" flag so the first hit in scan
  // order wins.
  always_comb begin
    nxt  = '0;
    last = 1'b1;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
`ifdef SEQ_MSB_FIRST_EN
      if (last && (SEL_W'(NUM_CH - 1 - j) < idx) && mask[SEL_W'(NUM_CH - 1 - j)]) begin
        nxt  = SEL_W'(NUM_CH - 1 - j);
        last = 1'b0;
      end
`else
      if (last && (SEL_W'(j) > idx) && mask[SEL_W'(j)]) begin
        nxt  = SEL_W'(j);
        last = 1'b0;
      end
`endif
    end
  end

endmodule

// File: rtl/demux_bit_sequencer.sv
// demux_bit_sequencer -- serialises 8-bit words onto a 1-to-8 demux, one bit
// per cycle, skipping channels whose mask bit is clear, with an optional
// idle gap after every word.
// Build option: SEQ_MSB_FIRST_EN scans from the highest enabled channel
// downward; default scans from the lowest upward.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   word_in     : data word, bit i goes to channel i
//   word_valid  : word_in / ch_mask valid
//   word_ready  : sequencer accepts a word on this edge if word_valid
//   ch_mask     : per-word channel enables, 1 = emit
//   dmx_in      : data bit to the demux (0 whenever dmx_valid is 0)
//   dmx_sel     : demux channel select
//   dmx_valid   : dmx_in / dmx_sel carry a real bit this cycle
//   word_done   : one-cycle pulse in the cycle after a word's last bit
//   busy        : high while shifting or in the gap
module demux_bit_sequencer #(
  parameter  int unsigned SEL_W  = demux_seq_pkg::SEL_W,
  localparam int unsigned NUM_CH = 2**SEL_W,
  parameter  int unsigned GAP    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              dmx_in,
  output logic [SEL_W-1:0]  dmx_sel,
  output logic              dmx_valid,
  output logic              word_done,
  output logic              busy
);

  import demux_seq_pkg::*;

  // The GAP parameter shadows the GAP state label, so states are always
  // referenced through the package scope below.

  // The word_done cycle is the first gap cycle, so the counter loads GAP-1.
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    (GAP == 0) ? '0 : GAP_CNT_W'(GAP - 1);

  demux_seq_pkg::seq_state_t state;

  logic [NUM_CH-1:0]    word_q;
  logic [NUM_CH-1:0]    mask_q;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic [SEL_W-1:0]     first_idx;
  logic                 first_none;
  logic [SEL_W-1:0]     nxt_idx;
  logic                 last;
  logic                 accept;
  logic                 end_word;

  // dmx_sel is the shift index itself: it only moves while shifting and
  // must hold its value through the gap anyway.
  demux_next_ch #(
    .SEL_W (SEL_W)
  ) u_next_ch (
    .mask (mask_q),
    .idx  (dmx_sel),
    .nxt  (nxt_idx),
    .last (last)
  );

  // First enabled channel of the incoming (not yet captured) mask.
  always_comb begin
    first_idx  = '0;
    first_none = 1'b1;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
`ifdef SEQ_MSB_FIRST_EN
      if (first_none && ch_mask[SEL_W'(NUM_CH - 1 - j)]) begin
        first_idx  = SEL_W'(NUM_CH - 1 - j);
        first_none = 1'b0;
      end
`else
      if (first_none && ch_mask[SEL_W'(j)]) begin
        first_idx  = SEL_W'(j);
        first_none = 1'b0;
      end
`endif
    end
  end

  // A zero-mask word ends in the same way as the last bit of a normal word:
  // the following cycle is the word_done cycle.
  always_comb begin
    accept   = word_valid && word_ready;
    end_word = (accept && first_none) ||
               ((state == demux_seq_pkg::SHIFT) && last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= demux_seq_pkg::IDLE;
      word_q     <= '0;
      mask_q     <= '0;
      gap_cnt    <= '0;
      word_ready <= 1'b1;
      dmx_in     <= 1'b0;
      dmx_sel    <= '0;
      dmx_valid  <= 1'b0;
      word_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      word_done <= 1'b0;

      if (accept) begin
        word_q <= word_in;
        mask_q <= ch_mask;
      end

      if (end_word) begin
        word_done <= 1'b1;
        dmx_valid <= 1'b0;
        dmx_in    <= 1'b0;
        if (GAP != 0) begin
          state      <= demux_seq_pkg::GAP;
          gap_cnt    <= GAP_LOAD;
          word_ready <= 1'b0;
          busy       <= 1'b1;
        end else begin
          state      <= demux_seq_pkg::IDLE;
          word_ready <= 1'b1;
          busy       <= 1'b0;
        end
      end else begin
        case (state)
          demux_seq_pkg::IDLE: begin
            dmx_valid <= 1'b0;
            dmx_in    <= 1'b0;
            if (accept) begin
              state      <= demux_seq_pkg::SHIFT;
              word_ready <= 1'b0;
              busy       <= 1'b1;
              dmx_valid  <= 1'b1;
              dmx_sel    <= first_idx;
              dmx_in     <= word_in[first_idx];
            end
          end
          demux_seq_pkg::SHIFT: begin
            dmx_valid <= 1'b1;
            dmx_sel   <= nxt_idx;
            dmx_in    <= word_q[nxt_idx];
          end
          demux_seq_pkg::GAP: begin
            dmx_valid <= 1'b0;
            dmx_in    <= 1'b0;
            if (gap_cnt == '0) begin
              state      <= demux_seq_pkg::IDLE;
              word_ready <= 1'b1;
              busy       <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          default: begin
            state      <= demux_seq_pkg::IDLE;
            word_ready <= 1'b1;
            busy       <= 1'b0;
            dmx_valid  <= 1'b0;
            dmx_in     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux_bit_sequencer.sv
// tb_demux_bit_sequencer -- directed bench for demux_bit_sequencer.
// Two instances share the stimulus: dut0 with GAP=0 and dut3 with GAP=3.
// Honours SEQ_MSB_FIRST_EN for the expected scan order.
module tb_demux_bit_sequencer;

`ifdef SEQ_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] word_in = '0;
  logic [7:0] ch_mask = '0;
  logic       word_valid = 1'b0;

  logic       ready0, din0, val0, done0, busy0;
  logic [2:0] sel0;
  logic       ready3, din3, val3, done3, busy3;
  logic [2:0] sel3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux_bit_sequencer #(.GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(ready0), .ch_mask(ch_mask), .dmx_in(din0), .dmx_sel(sel0),
    .dmx_valid(val0), .word_done(done0), .busy(busy0)
  );

  demux_bit_sequencer #(.GAP(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .word_ready(ready3), .ch_mask(ch_mask), .dmx_in(din3), .dmx_sel(sel3),
    .dmx_valid(val3), .word_done(done3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    word_valid = 1'b0;
    word_in    = '0;
    ch_mask    = '0;
    rst_n      = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic int unsigned ord(input int unsigned i);
    return MSB ? 7 - i : i;
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0]  bits;
    int unsigned c;
    int unsigned sp [3];

    // reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(ready0), 1);
    check("rst_din",   32'(din0),   0);
    check("rst_sel",   32'(sel0),   0);
    check("rst_valid", 32'(val0),   0);
    check("rst_done",  32'(done0),  0);
    check("rst_busy",  32'(busy0),  0);
    check("rst_ready3", 32'(ready3), 1);
    reset_all();

    // full mask, A5: bits 1,0,1,0,0,1,0,1 on ch 0..7
    bits = 8'b1010_0101;
    word_in = 8'hA5; ch_mask = 8'hFF; word_valid = 1'b1;
    step();
    word_valid = 1'b0; word_in = 8'h00; ch_mask = 8'h00;
    check("full_ready_low", 32'(ready0), 0);
    check("full_busy", 32'(busy0), 1);
    for (int unsigned i = 0; i < 8; i++) begin
      c = ord(i);
      check("full_valid", 32'(val0), 1);
      check("full_sel",   32'(sel0), c);
      check("full_din",   32'(din0), 32'(bits[c]));
      check("full_nodone", 32'(done0), 0);
      step();
    end
    check("full_done",       32'(done0), 1);
    check("full_done_valid", 32'(val0),  0);
    check("full_done_din",   32'(din0),  0);
    check("full_done_ready", 32'(ready0), 1);
    check("full_done_busy",  32'(busy0), 0);
    check("full_done_sel",   32'(sel0),  ord(7));
    step();
    check("full_done_pulse", 32'(done0), 0);

    // sparse mask 1000_0101 -> ch 0,2,7 only
    reset_all();
    sp = '{0, 2, 7};
    word_in = 8'hFF; ch_mask = 8'b1000_0101; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      c = MSB ? sp[2 - i] : sp[i];
      check("sparse_valid", 32'(val0), 1);
      check("sparse_sel",   32'(sel0), c);
      check("sparse_din",   32'(din0), 1);
      step();
    end
    check("sparse_done",  32'(done0), 1);
    check("sparse_valid_end", 32'(val0), 0);

    // zero mask on both instances
    reset_all();
    word_in = 8'hFF; ch_mask = 8'h00; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    check("zero_valid0", 32'(val0),   0);
    check("zero_done0",  32'(done0),  1);
    check("zero_ready0", 32'(ready0), 1);
    check("zero_busy0",  32'(busy0),  0);
    check("zero_valid3", 32'(val3),   0);
    check("zero_done3",  32'(done3),  1);
    check("zero_ready3", 32'(ready3), 0);
    check("zero_busy3",  32'(busy3),  1);
    step();
    check("zero_gap2_ready3", 32'(ready3), 0);
    check("zero_gap2_done3",  32'(done3),  0);
    step();
    check("zero_gap3_ready3", 32'(ready3), 0);
    step();
    check("zero_idle_ready3", 32'(ready3), 1);
    check("zero_idle_busy3",  32'(busy3),  0);

    // back-to-back with word_valid held; word 10/mask 18 then 01/mask 01
    reset_all();
    word_in = 8'h10; ch_mask = 8'h18; word_valid = 1'b1;
    step();
    word_in = 8'h01; ch_mask = 8'h01;
    check("b2b_c1_sel3", 32'(sel3), MSB ? 4 : 3);
    check("b2b_c1_din3", 32'(din3), MSB ? 1 : 0);
    check("b2b_c1_sel0", 32'(sel0), MSB ? 4 : 3);
    step();
    check("b2b_c2_sel3", 32'(sel3), MSB ? 3 : 4);
    check("b2b_c2_din3", 32'(din3), MSB ? 0 : 1);
    step();
    check("b2b_c3_done3",  32'(done3),  1);
    check("b2b_c3_ready3", 32'(ready3), 0);
    check("b2b_c3_valid3", 32'(val3),   0);
    check("b2b_c3_done0",  32'(done0),  1);
    check("b2b_c3_ready0", 32'(ready0), 1);
    step();
    check("b2b_c4_ready3", 32'(ready3), 0);
    check("b2b_c4_done3",  32'(done3),  0);
    check("b2b_c4_valid0", 32'(val0),   1);
    check("b2b_c4_sel0",   32'(sel0),   0);
    check("b2b_c4_din0",   32'(din0),   1);
    check("b2b_c4_ready0", 32'(ready0), 0);
    step();
    check("b2b_c5_ready3", 32'(ready3), 0);
    check("b2b_c5_done0",  32'(done0),  1);
    step();
    check("b2b_c6_ready3", 32'(ready3), 1);
    check("b2b_c6_valid3", 32'(val3),   0);
    check("b2b_c6_busy3",  32'(busy3),  0);
    step();
    word_valid = 1'b0;
    check("b2b_c7_valid3", 32'(val3),   1);
    check("b2b_c7_sel3",   32'(sel3),   0);
    check("b2b_c7_din3",   32'(din3),   1);
    check("b2b_c7_ready3", 32'(ready3), 0);
    step();
    check("b2b_c8_done3",  32'(done3),  1);

    // reset during the 4th bit of 3C/FF
    reset_all();
    bits = 8'h3C;
    word_in = 8'h3C; ch_mask = 8'hFF; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    step();
    step();
    step();
    check("mid_valid", 32'(val0), 1);
    check("mid_sel",   32'(sel0), ord(3));
    check("mid_din",   32'(din0), 32'(bits[ord(3)]));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(val0),   0);
    check("mid_rst_din",   32'(din0),   0);
    check("mid_rst_sel",   32'(sel0),   0);
    check("mid_rst_ready", 32'(ready0), 1);
    check("mid_rst_busy",  32'(busy0),  0);
    check("mid_rst_done",  32'(done0),  0);
    step();
    rst_n = 1'b1;
    step();
    check("mid_post_done",  32'(done0), 0);
    check("mid_post_valid", 32'(val0),  0);
    bits = 8'h01;
    word_in = 8'h01; ch_mask = 8'hFF; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    check("mid_new_sel", 32'(sel0), ord(0));
    check("mid_new_din", 32'(din0), 32'(bits[ord(0)]));

`ifdef SEQ_MSB_FIRST_EN
    // MSB-first: word 01, mask 81 -> ch7 (0), then ch0 (1)
    reset_all();
    word_in = 8'h01; ch_mask = 8'h81; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    check("msb_sel_a", 32'(sel0), 7);
    check("msb_din_a", 32'(din0), 0);
    step();
    check("msb_sel_b", 32'(sel0), 0);
    check("msb_din_b", 32'(din0), 1);
    step();
    check("msb_done", 32'(done0), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
